// File: rtl/vector_argmax_pkg.sv
// Shared float32 definitions used by the argmax, division and exponent stages.
package vector_argmax_pkg;

    localparam int unsigned FP_WIDTH  = 32;
    localparam int unsigned FP_EXP_W  = 8;
    localparam int unsigned FP_MANT_W = 23;

    localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

    typedef struct packed {
        logic                 sign;
        logic [FP_EXP_W-1:0]  exp;
        logic [FP_MANT_W-1:0] mant;
    } fp32_t;

    // A NaN has an all-ones exponent and a non-zero mantissa; Inf has a zero mantissa.
    function automatic logic fp_is_nan(input fp32_t f);
        return (f.exp == FP_EXP_MAX) && (f.mant != '0);
    endfunction

endpackage

// File: rtl/vector_argmax_float_greater_than.sv
// Combinational strict greater-than for IEEE-754 single values.
// NaN ranks below every non-NaN value, -0 equals +0, and +/-Inf and
// denormals fall out of the ordinary sign/magnitude ordering.
module float_greater_than
    import vector_argmax_pkg::*;
(
    input  logic [FP_WIDTH-1:0] a,
    input  logic [FP_WIDTH-1:0] b,
    output logic                gt,
    output logic                a_is_nan
);

    fp32_t fa;
    fp32_t fb;
    logic  b_is_nan;
    logic  a_zero;
    logic  b_zero;

    assign fa = fp32_t'(a);
    assign fb = fp32_t'(b);

    // Classify operands and resolve a > b.
    always_comb begin
        a_is_nan = fp_is_nan(fa);
        b_is_nan = fp_is_nan(fb);
        a_zero   = ({fa.exp, fa.mant} == '0);
        b_zero   = ({fb.exp, fb.mant} == '0);
        gt       = 1'b0;
        if (a_is_nan) begin
            gt = 1'b0;
        end else if (b_is_nan) begin
            gt = 1'b1;
        end else if (a_zero && b_zero) begin
            gt = 1'b0;
        end else if (fa.sign != fb.sign) begin
            gt = ~fa.sign;
        end else if (!fa.sign) begin
            gt = ({fa.exp, fa.mant} > {fb.exp, fb.mant});
        end else begin
            gt = ({fa.exp, fa.mant} < {fb.exp, fb.mant});
        end
    end

endmodule

// File: rtl/vector_argmax.sv
// Sequential argmax over a float32 vector: one element compared per cycle
// through a single shared comparator, with valid/ready on both sides.
module vector_argmax
    import vector_argmax_pkg::*;
#(
    parameter  int unsigned VLEN = 4,
    localparam int unsigned IDXW = (VLEN > 1) ? $clog2(VLEN) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [FP_WIDTH*VLEN-1:0] in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [IDXW-1:0]          class_idx,
    output logic [FP_WIDTH-1:0]      max_val,
    output logic                     all_nan,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDXW:0] CNT_LAST = (IDXW+1)'(VLEN - 1);

    logic [1:0]               state_q;
    logic [FP_WIDTH*VLEN-1:0] vec_q;
    logic [FP_WIDTH-1:0]      best_q;
    logic [IDXW-1:0]          idx_q;
    logic [IDXW:0]            cnt_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic [IDXW-1:0]          class_idx_q;
    logic [FP_WIDTH-1:0]      max_val_q;
    logic                     all_nan_q;

    logic [FP_WIDTH-1:0]      elem;
    logic [FP_WIDTH-1:0]      cmp_a;
    logic                     cmp_gt;
    logic                     cmp_a_nan;

    // Select the element addressed by the scan counter.
    always_comb begin
        elem = '0;
        for (int unsigned i = 0; i < VLEN; i++) begin
            if (cnt_q == (IDXW+1)'(i)) begin
                elem = vec_q[FP_WIDTH*i +: FP_WIDTH];
            end
        end
    end

    // In DONE the comparator's NaN detector is reused on the winner:
    // a NaN winner can only survive if every element was NaN.
    always_comb begin
        cmp_a = (state_q == ST_DONE) ? best_q : elem;
    end

    float_greater_than u_cmp (
        .a        (cmp_a),
        .b        (best_q),
        .gt       (cmp_gt),
        .a_is_nan (cmp_a_nan)
    );

    // Control FSM, scan datapath and registered result/handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            vec_q       <= '0;
            best_q      <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            class_idx_q <= '0;
            max_val_q   <= '0;
            all_nan_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        vec_q      <= in;
                        best_q     <= in[FP_WIDTH-1:0];
                        idx_q      <= '0;
                        cnt_q      <= (IDXW+1)'(1);
                        in_ready_q <= 1'b0;
                        state_q    <= (VLEN == 1) ? ST_DONE : ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (cmp_gt) begin
                        best_q <= elem;
                        idx_q  <= cnt_q[IDXW-1:0];
                    end
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        class_idx_q <= idx_q;
                        max_val_q   <= best_q;
                        all_nan_q   <= cmp_a_nan;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign class_idx = class_idx_q;
    assign max_val   = max_val_q;
    assign all_nan   = all_nan_q;

endmodule

// File: tb/tb_vector_argmax.sv
// Bench for vector_argmax: directed table, handshake/reset sequences,
// a VLEN=1 instance, and random vectors against a real-valued model.
module tb_vector_argmax;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_v;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   class_idx;
    logic [31:0]  max_val;
    logic         all_nan;
    logic         out_valid;
    logic         out_ready;

    logic [31:0]  in1;
    logic         in_valid1;
    logic         in_ready1;
    logic [0:0]   class_idx1;
    logic [31:0]  max_val1;
    logic         all_nan1;
    logic         out_valid1;
    logic         out_ready1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vector_argmax #(.VLEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in_v),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .class_idx (class_idx),
        .max_val   (max_val),
        .all_nan   (all_nan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    vector_argmax #(.VLEN(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in        (in1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .class_idx (class_idx1),
        .max_val   (max_val1),
        .all_nan   (all_nan1),
        .out_valid (out_valid1),
        .out_ready (out_ready1)
    );

    typedef struct {
        string        name;
        logic [127:0] v;
        int           idx;
        logic [31:0]  mx;
        logic         nan;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Numeric value of a float32 pattern; Inf maps beyond every finite float.
    function automatic real to_real(input logic [31:0] b);
        real mag;
        int  e;
        e = int'(b[30:23]);
        if (e == 255) mag = 1.0e300;
        else if (e == 0) mag = real'(b[22:0]) * (2.0 ** (-149.0));
        else mag = (real'(b[22:0]) + 8388608.0) * (2.0 ** real'(e - 150));
        return b[31] ? -mag : mag;
    endfunction

    function automatic logic is_nan(input logic [31:0] b);
        return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    endfunction

    // First index holding the largest numeric value, NaNs ignored.
    task automatic model4(input logic [127:0] v, output int idx, output logic [31:0] mx,
                          output logic nan);
        real         best;
        logic [31:0] e;
        idx  = -1;
        best = 0.0;
        for (int i = 0; i < 4; i++) begin
            e = v[32*i +: 32];
            if (!is_nan(e) && (idx < 0 || to_real(e) > best)) begin
                idx  = i;
                best = to_real(e);
            end
        end
        nan = (idx < 0);
        if (idx < 0) idx = 0;
        mx = v[32*idx +: 32];
    endtask

    task automatic send4(input string name, input logic [127:0] v, input int exp_idx,
                         input logic [31:0] exp_max, input logic exp_nan);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_ready_pre"}, in_ready, 1);
        in_v     = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_v     = {$urandom, $urandom, $urandom, $urandom};
        chk({name, "_ready_busy"}, in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_latency"}, n, 4);
        chk({name, "_idx"}, class_idx, exp_idx);
        chk({name, "_max"}, max_val, exp_max);
        chk({name, "_nan"}, all_nan, exp_nan);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_valid_clr"}, out_valid, 0);
        chk({name, "_ready_post"}, in_ready, 1);
    endtask

    initial begin
        int          n;
        int          ridx;
        logic [31:0] rmx;
        logic        rnan;
        logic [127:0] rv;
        logic [31:0] el;
        logic [31:0] pool [8];

        pool = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                 32'h7FC00000, 32'h00000001, 32'h80000001, 32'h3F800000};

        tbl.push_back('{"basic",   {32'h3E000000, 32'h3F000000, 32'h3E800000, 32'h3E000000}, 2, 32'h3F000000, 1'b0});
        tbl.push_back('{"tie_all", {32'h3E800000, 32'h3E800000, 32'h3E800000, 32'h3E800000}, 0, 32'h3E800000, 1'b0});
        tbl.push_back('{"tie_13",  {32'h3F800000, 32'h00000000, 32'h3F800000, 32'h00000000}, 1, 32'h3F800000, 1'b0});
        tbl.push_back('{"nan_zero",{32'h7FC00000, 32'h00000000, 32'h80000000, 32'h7FC00000}, 1, 32'h80000000, 1'b0});
        tbl.push_back('{"all_nan", {32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000}, 0, 32'h7FC00000, 1'b1});
        tbl.push_back('{"nan_mix", {32'h7F800001, 32'hFFC00000, 32'h7FFFFFFF, 32'hFF800001}, 0, 32'hFF800001, 1'b1});
        tbl.push_back('{"inf",     {32'hFF800000, 32'h00000001, 32'h80000005, 32'h7F800000}, 0, 32'h7F800000, 1'b0});
        tbl.push_back('{"denorm",  {32'h00000002, 32'h00000001, 32'hBF800000, 32'hFFC00000}, 3, 32'h00000002, 1'b0});
        tbl.push_back('{"negs",    {32'hC0000000, 32'hBF800000, 32'hC0400000, 32'hFF800000}, 2, 32'hBF800000, 1'b0});

        rst        = 1'b0;
        in_v       = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        in1        = '0;
        in_valid1  = 1'b0;
        out_ready1 = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_idx", class_idx, 0);
        chk("rst_max", max_val, 0);
        chk("rst_nan", all_nan, 0);
        chk("rst_out_valid1", out_valid1, 0);
        tick();
        tick();
        rst = 1'b0;
        chk("rel_ready_low", in_ready, 0);
        tick();
        chk("rel_ready_high", in_ready, 1);
        chk("rel_ready_high1", in_ready1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            send4(tbl[i].name, tbl[i].v, tbl[i].idx, tbl[i].mx, tbl[i].nan);
        end

        // Back-pressure: result held and a presented vector is refused.
        in_v     = {32'h3E000000, 32'h3F000000, 32'h3E800000, 32'h3E000000};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("bp_latency", n, 4);
        for (int i = 0; i < 10; i++) begin
            in_v     = {32'h7F000000, 32'h7F000000, 32'h7F000000, 32'h7F000000};
            in_valid = 1'b1;
            tick();
            chk($sformatf("bp_valid_%0d", i), out_valid, 1);
            chk($sformatf("bp_idx_%0d", i), class_idx, 2);
            chk($sformatf("bp_max_%0d", i), max_val, 32'h3F000000);
            chk($sformatf("bp_ready_%0d", i), in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_ready", in_ready, 1);
        chk("bp_release_valid", out_valid, 0);
        chk("bp_release_max", max_val, 32'h3F000000);

        // Reset during SCAN.
        in_v     = {32'h40000000, 32'h3F800000, 32'h3F000000, 32'h3E000000};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("rscan_valid", out_valid, 0);
        chk("rscan_ready", in_ready, 0);
        chk("rscan_idx", class_idx, 0);
        tick();
        rst = 1'b0;
        chk("rscan_ready_low", in_ready, 0);
        tick();
        chk("rscan_ready_high", in_ready, 1);
        chk("rscan_valid_low", out_valid, 0);
        send4("after_rscan", {32'h3E000000, 32'h3F000000, 32'h3E800000, 32'h3E000000}, 2, 32'h3F000000, 1'b0);

        // Reset during DONE: the held result must vanish with no later pulse.
        in_v     = {32'h3F800000, 32'h3E000000, 32'h3E000000, 32'h3E000000};
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("rdone_latency", n, 4);
        rst = 1'b1;
        #1;
        chk("rdone_valid", out_valid, 0);
        chk("rdone_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) n++;
        end
        chk("rdone_no_pulse", n, 0);
        send4("after_rdone", {32'hBF800000, 32'h00000000, 32'h3F000000, 32'h3E000000}, 1, 32'h3F000000, 1'b0);

        // VLEN=1 instance.
        in1       = 32'h40490FDB;
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        in1       = 32'h00000000;
        n = 0;
        while (!out_valid1 && n < 20) begin
            tick();
            n++;
        end
        chk("v1_latency", n, 1);
        chk("v1_idx", class_idx1, 0);
        chk("v1_max", max_val1, 32'h40490FDB);
        chk("v1_nan", all_nan1, 0);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        chk("v1_ready_post", in_ready1, 1);
        in1       = 32'h7FC00001;
        in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 20) begin
            tick();
            n++;
        end
        chk("v1nan_latency", n, 1);
        chk("v1nan_max", max_val1, 32'h7FC00001);
        chk("v1nan_nan", all_nan1, 1);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;

        // Random vectors with specials and ties against the model.
        for (int t = 0; t < 150; t++) begin
            rv = '0;
            el = $urandom;
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 5))
                    0, 1:    el = $urandom;
                    2:       el = pool[$urandom_range(0, 7)];
                    3:       el = el;
                    4:       el = {1'b0, 8'($urandom_range(120, 130)), 23'($urandom)};
                    default: el = {1'b1, 8'($urandom_range(0, 2)), 23'($urandom_range(0, 3))};
                endcase
                rv[32*i +: 32] = el;
            end
            model4(rv, ridx, rmx, rnan);
            send4($sformatf("rand_%0d", t), rv, ridx, rmx, rnan);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
